// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the processor run controller: FSM state codes,
// stop-cause codes and the default program-end instruction word.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_BREAK   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping so a long run never reports a small retire count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         start_up,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = {W{1'b1}};

  always_ff @(posedge clk or posedge start_up) begin
    if (start_up) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run controller for the single-cycle processor: reset sequencing, launch,
// per-cycle commit gating, single-step, and stop on halt/break/budget/user.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int          INIT_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES  = 32'd0,
  parameter logic [31:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        start_up,
  input  logic        go,
  input  logic        step,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        proc_rst,
  output logic        pc_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired
);

  localparam int              CW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]   INIT_LOAD = CW'(INIT_CYCLES - 1);

  state_t        cur;
  state_t        nxt;
  cause_t        cause_q;
  cause_t        cause_nxt;
  logic          set_cause;
  logic          launch;
  logic          launch_paused;
  logic          resume;
  logic          mode_pause;
  logic          bp_skip;
  logic [CW-1:0] init_cnt;
  logic          hit_halt;
  logic          hit_bp;
  logic          hit_budget;

  assign hit_halt   = (instruction == HALT_WORD);
  assign hit_bp     = bp_en && (pc == bp_addr) && !bp_skip;
  assign hit_budget = (MAX_CYCLES != 32'd0) && (retired == MAX_CYCLES);

  always_comb begin
    nxt           = cur;
    pc_en         = 1'b0;
    launch        = 1'b0;
    launch_paused = 1'b0;
    resume        = 1'b0;
    set_cause     = 1'b0;
    cause_nxt     = CAUSE_NONE;
    case (cur)
      ST_IDLE: begin
        if (go) begin
          nxt    = ST_INIT;
          launch = 1'b1;
        end else if (step) begin
          nxt           = ST_INIT;
          launch        = 1'b1;
          launch_paused = 1'b1;
        end
      end
      ST_INIT: begin
        if (init_cnt == '0) begin
          nxt = mode_pause ? ST_PAUSE : ST_RUN;
        end
      end
      // A stop suppresses the commit of the instruction that triggered it.
      ST_RUN: begin
        set_cause = 1'b1;
        if (hit_halt) begin
          nxt       = ST_DONE;
          cause_nxt = CAUSE_HALT;
        end else if (hit_bp) begin
          nxt       = ST_PAUSE;
          cause_nxt = CAUSE_BREAK;
        end else if (hit_budget) begin
          nxt       = ST_DONE;
          cause_nxt = CAUSE_TIMEOUT;
        end else if (halt_req) begin
          nxt       = ST_PAUSE;
          cause_nxt = CAUSE_NONE;
        end else begin
          set_cause = 1'b0;
          pc_en     = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (go) begin
          nxt    = ST_RUN;
          resume = 1'b1;
        end else if (step) begin
          nxt    = ST_STEP;
          resume = 1'b1;
        end
      end
      ST_STEP: begin
        if (hit_halt) begin
          nxt       = ST_DONE;
          set_cause = 1'b1;
          cause_nxt = CAUSE_HALT;
        end else if (hit_budget) begin
          nxt       = ST_DONE;
          set_cause = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          nxt   = ST_PAUSE;
          pc_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (go) begin
          nxt    = ST_INIT;
          launch = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge start_up) begin
    if (start_up) begin
      cur        <= ST_IDLE;
      init_cnt   <= '0;
      bp_skip    <= 1'b0;
      mode_pause <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      cur <= nxt;
      if (launch) begin
        init_cnt   <= INIT_LOAD;
        mode_pause <= launch_paused;
        cause_q    <= CAUSE_NONE;
      end else begin
        if ((cur == ST_INIT) && (init_cnt != '0)) begin
          init_cnt <= init_cnt - 1'b1;
        end
        if (set_cause) begin
          cause_q <= cause_nxt;
        end
      end
      // Skip lets the instruction sitting on a breakpoint execute once after resume.
      if (resume) begin
        bp_skip <= 1'b1;
      end else if ((cur == ST_RUN) || (cur == ST_STEP)) begin
        bp_skip <= 1'b0;
      end
    end
  end

  sat_counter #(.W(32)) u_retired (
    .clk      (clk),
    .start_up (start_up),
    .clr      (launch),
    .inc      (pc_en),
    .q        (retired)
  );

  assign state      = cur;
  assign halt_cause = cause_q;
  assign halted     = (cur == ST_DONE);
  assign proc_rst   = (cur == ST_IDLE) || (cur == ST_INIT);

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: a program-memory processor stand-in,
// a run-level reference predictor, and a cycle monitor that checks stop events.
module tb_run_controller;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        start_up, go, step, halt_req, bp_en;
  logic [31:0] bp_addr, instruction;
  logic [31:0] pc = 32'd0;
  logic        proc_rst, pc_en, halted;
  logic [2:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] retired;
  logic [31:0] prog [0:63];
  logic        hr_en;
  logic [31:0] hr_addr;

  logic        go_b, tie0;
  logic [31:0] tie32, instr_b;
  logic [31:0] pc_b = 32'd0;
  logic        proc_rst_b, pc_en_b, halted_b;
  logic [2:0]  state_b;
  logic [1:0]  cause_b;
  logic [31:0] retired_b;

  always #5 clk = ~clk;

  assign instruction = prog[pc[7:2]];
  assign halt_req    = hr_en && (pc == hr_addr);
  assign instr_b     = NOP;

  always @(posedge clk) begin
    if (proc_rst) pc <= 32'd0;
    else if (pc_en) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (proc_rst_b) pc_b <= 32'd0;
    else if (pc_en_b) pc_b <= pc_b + 32'd4;
  end

  run_controller #(.INIT_CYCLES(2), .MAX_CYCLES(32'd0), .HALT_WORD(HALT)) dut (
    .clk(clk), .start_up(start_up), .go(go), .step(step), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instruction(instruction),
    .proc_rst(proc_rst), .pc_en(pc_en), .state(state), .halted(halted),
    .halt_cause(halt_cause), .retired(retired)
  );

  run_controller #(.INIT_CYCLES(2), .MAX_CYCLES(32'd4), .HALT_WORD(HALT)) dut_b (
    .clk(clk), .start_up(start_up), .go(go_b), .step(tie0), .halt_req(tie0),
    .bp_en(tie0), .bp_addr(tie32), .pc(pc_b), .instruction(instr_b),
    .proc_rst(proc_rst_b), .pc_en(pc_en_b), .state(state_b), .halted(halted_b),
    .halt_cause(cause_b), .retired(retired_b)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  cause;
    logic        chk_cause;
    logic [31:0] ret;
    logic [31:0] pcv;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_mode = 3'd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: per-cycle rules plus scoreboard pop on every RUN/STEP -> PAUSE/DONE stop.
  initial begin
    logic [2:0]  ps;
    logic        ppe;
    logic [31:0] pret;
    int          icnt;
    exp_t        e;
    ps = 3'd0; ppe = 1'b0; pret = 32'd0; icnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start_up) begin
        icnt = 0;
      end else begin
        check("proc_rst_rule", {31'd0, proc_rst}, {31'd0, (state == 3'd0) || (state == 3'd1)});
        check("halted_rule", {31'd0, halted}, {31'd0, state == 3'd5});
        if (state == 3'd1) check("retired_clear_init", retired, 32'd0);
        else check("retired_counts_commits", retired, pret + {31'd0, ppe});
        if (state == 3'd1) begin
          icnt++;
        end else if (ps == 3'd1) begin
          check("init_length", icnt, 2);
          check("init_exit_state", {29'd0, state}, {29'd0, exp_mode});
          icnt = 0;
        end
        if (((ps == 3'd2) || (ps == 3'd4)) && ((state == 3'd3) || (state == 3'd5))) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_stop actual_state=%0d required=no_stop", state);
          end else begin
            e = sb.pop_front();
            check("stop_state", {29'd0, state}, {29'd0, e.st});
            check("stop_retired", retired, e.ret);
            check("stop_pc", pc, e.pcv);
            if (e.chk_cause) check("stop_cause", {30'd0, halt_cause}, {30'd0, e.cause});
          end
        end
      end
      ps = state; ppe = pc_en; pret = retired;
    end
  end

  // Reference: scan forward from index idx for the first stop rule that applies.
  function automatic int predict(input int idx, input bit skip,
                                 output logic [2:0] st, output logic [1:0] cause);
    for (int i = idx; i < 64; i++) begin
      if (prog[i] == HALT) begin st = 3'd5; cause = 2'd1; return i; end
      if (bp_en && (bp_addr == 32'(4 * i)) && !(skip && (i == idx))) begin
        st = 3'd3; cause = 2'd2; return i;
      end
      if (hr_en && (hr_addr == 32'(4 * i))) begin st = 3'd3; cause = 2'd0; return i; end
    end
    st = 3'd0; cause = 2'd0;
    return 64;
  endfunction

  task automatic pulse(input logic g, input logic s, input int len);
    @(negedge clk);
    go = g; step = s;
    repeat (len) @(negedge clk);
    go = 1'b0; step = 1'b0;
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] c, input logic cc,
                      input int ret, input int at);
    exp_t e;
    e.st = st; e.cause = c; e.chk_cause = cc; e.ret = 32'(ret); e.pcv = 32'(4 * at);
    sb.push_back(e);
  endtask

  task automatic wait_sb(input string name);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic trial(input int h, input bit bpe, input int b, input bit hre,
                       input int u, input bit paused_in);
    int         idx, ret, stop, a, guard;
    logic [2:0] st;
    logic [1:0] cause;
    bit         paused;
    paused = paused_in && (state == 3'd0);
    for (int i = 0; i < 64; i++) prog[i] = $urandom() & 32'h7FFF_FFFF;
    prog[h] = HALT;
    bp_en = bpe; bp_addr = 32'(4 * b); hr_en = hre; hr_addr = 32'(4 * u);
    idx = 0; ret = 0;
    if (paused) begin
      exp_mode = 3'd3;
      pulse(1'b0, 1'b1, 1 + int'($urandom_range(0, 1)));
      for (int k = 0; k < 20 && state != 3'd3; k++) @(negedge clk);
      check("paused_launch_state", {29'd0, state}, 32'd3);
      check("paused_launch_retired", retired, 32'd0);
      check("paused_launch_pc", pc, 32'd0);
      st = 3'd3;
    end else begin
      exp_mode = 3'd2;
      stop = predict(0, 1'b0, st, cause);
      push(st, cause, 1'b1, stop, stop);
      pulse(1'b1, 1'(($urandom_range(0, 1))), 1 + int'($urandom_range(0, 1)));
      wait_sb("launch_stop");
      ret = stop; idx = stop;
    end
    guard = 0;
    while ((st == 3'd3) && (guard < 100)) begin
      guard++;
      if (hr_en && (hr_addr == 32'(4 * idx))) hr_en = 1'b0;
      a = int'($urandom_range(0, 2));
      if (a == 1) begin
        if (prog[idx] == HALT) begin
          st = 3'd5;
          push(3'd5, 2'd1, 1'b1, ret, idx);
        end else begin
          st = 3'd3;
          push(3'd3, 2'd0, 1'b0, ret + 1, idx + 1);
          idx++; ret++;
        end
        pulse(1'b0, 1'b1, 1);
      end else begin
        stop = predict(idx, 1'b1, st, cause);
        push(st, cause, 1'b1, ret + stop - idx, stop);
        pulse(1'b1, 1'(a == 2), 1);
        ret = ret + stop - idx; idx = stop;
      end
      wait_sb("resume_stop");
    end
    check("trial_ends_done", {29'd0, state}, 32'd5);
    if ($urandom_range(0, 1) == 1) begin
      pulse(1'b0, 1'b1, 1);
      repeat (3) @(negedge clk);
      check("step_ignored_in_done", {29'd0, state}, 32'd5);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    start_up = 1'b1; go = 1'b0; step = 1'b0; go_b = 1'b0; tie0 = 1'b0; tie32 = 32'd0;
    bp_en = 1'b0; bp_addr = 32'd0; hr_en = 1'b0; hr_addr = 32'd0;
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    #2;
    check("reset_state", {29'd0, state}, 32'd0);
    check("reset_proc_rst", {31'd0, proc_rst}, 32'd1);
    check("reset_pc_en", {31'd0, pc_en}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_cause", {30'd0, halt_cause}, 32'd0);
    check("reset_retired", retired, 32'd0);
    repeat (2) @(negedge clk);
    start_up = 1'b0;

    trial(6, 1'b0, 0, 1'b0, 0, 1'b1);
    trial(5, 1'b0, 0, 1'b0, 0, 1'b0);
    trial(12, 1'b1, 2, 1'b0, 0, 1'b0);
    trial(20, 1'b1, 4, 1'b1, 9, 1'b0);
    for (int t = 0; t < 30; t++) begin
      trial(int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b0);
    end

    for (int i = 0; i < 64; i++) prog[i] = NOP;
    prog[60] = HALT; bp_en = 1'b0; hr_en = 1'b0; exp_mode = 3'd2;
    pulse(1'b1, 1'b0, 1);
    for (int k = 0; k < 20 && state != 3'd2; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    check("run_before_reset_pc_en", {31'd0, pc_en}, 32'd1);
    start_up = 1'b1;
    #1;
    check("midrun_reset_pc_en", {31'd0, pc_en}, 32'd0);
    check("midrun_reset_proc_rst", {31'd0, proc_rst}, 32'd1);
    check("midrun_reset_state", {29'd0, state}, 32'd0);
    check("midrun_reset_retired", retired, 32'd0);
    @(negedge clk);
    start_up = 1'b0;
    trial(int'($urandom_range(3, 30)), 1'b1, int'($urandom_range(0, 10)), 1'b1,
          int'($urandom_range(0, 20)), 1'b1);

    @(negedge clk); go_b = 1'b1; @(negedge clk); go_b = 1'b0;
    for (int k = 0; k < 40 && !halted_b; k++) @(negedge clk);
    check("budget_state", {29'd0, state_b}, 32'd5);
    check("budget_cause", {30'd0, cause_b}, 32'd3);
    check("budget_retired", retired_b, 32'd4);
    check("budget_pc", pc_b, 32'h10);
    @(negedge clk); go_b = 1'b1; @(negedge clk); go_b = 1'b0;
    #1;
    check("relaunch_state_init", {29'd0, state_b}, 32'd1);
    check("relaunch_retired_clear", retired_b, 32'd0);
    check("relaunch_cause_clear", {30'd0, cause_b}, 32'd0);
    for (int k = 0; k < 40 && !halted_b; k++) @(negedge clk);
    check("budget_again_retired", retired_b, 32'd4);
    check("budget_again_cause", {30'd0, cause_b}, 32'd3);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
